// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg
// Shared definitions for the output-RAM port arbiter: owner tags that travel
// with each RAM read, the owner FSM state encoding, and the default RAM
// geometry (64 x 16).
package ram_arb_pkg;

    localparam int DEF_ADDR_W = 6;
    localparam int DEF_DATA_W = 16;

    // Who issued an access; OWN_NONE marks a pipeline slot with no read.
    typedef enum logic [1:0] {
        OWN_NONE = 2'b00,
        OWN_CPU  = 2'b01,
        OWN_RD   = 2'b10
    } owner_e;

    // Owner FSM: which requester, if any, currently holds the lock.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_OWN_CPU = 2'b01,
        ST_OWN_RD  = 2'b10
    } arb_state_e;

endpackage

// File: rtl/ram_rd_tag_pipe.sv
// ram_rd_tag_pipe
// Shift register of owner tags, RD_LAT+1 stages deep. A tag pushed in the
// accept cycle reaches the last stage in the same cycle the RAM presents the
// matching douta word, so the strobes line up with ram_dout.
// Ports:
//   clk, reset  - clock, synchronous active-high reset (clears all tags)
//   tag_in      - owner of the access accepted this cycle (OWN_NONE if none/write)
//   cpu_vld     - last stage holds a CPU read tag
//   rd_vld      - last stage holds a readout read tag
module ram_rd_tag_pipe
    import ram_arb_pkg::*;
#(
    parameter int RD_LAT = 1
) (
    input  logic   clk,
    input  logic   reset,
    input  owner_e tag_in,
    output logic   cpu_vld,
    output logic   rd_vld
);

    localparam int DEPTH = RD_LAT + 1;

    owner_e tag_p [DEPTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                tag_p[i] <= OWN_NONE;
            end
        end else begin
            tag_p[0] <= tag_in;
            for (int i = 1; i < DEPTH; i++) begin
                tag_p[i] <= tag_p[i-1];
            end
        end
    end

    assign cpu_vld = (tag_p[DEPTH-1] == OWN_CPU);
    assign rd_vld  = (tag_p[DEPTH-1] == OWN_RD);

endmodule

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter
// Registered request/grant arbiter sharing one single-port RAM between the
// CPU and the RAM-readout/UART engine. Reads are tagged so each douta word
// is returned only to the requester that issued it.
// Ports:
//   clk, reset                       - clock, synchronous active-high reset
//   cpu_req/we/lock/addr/wdata       - CPU access request (held until granted)
//   cpu_gnt                          - CPU access accepted this cycle (comb)
//   cpu_rvalid, cpu_rdata            - CPU read response (rdata holds)
//   rd_*                             - same set for the readout engine
//   ram_ena/wea/addr/din             - registered RAM port drive
//   ram_dout                         - RAM douta, RD_LAT cycles after address
module ram_port_arbiter
    import ram_arb_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int RD_LAT   = 1,
    parameter int ARB_MODE = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic              cpu_lock,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              rd_req,
    input  logic              rd_we,
    input  logic              rd_lock,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_wdata,
    output logic              rd_gnt,
    output logic              rd_rvalid,
    output logic [DATA_W-1:0] rd_rdata,
    output logic              ram_ena,
    output logic              ram_wea,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout
);

    arb_state_e        state, state_nxt;
    owner_e            last_gnt;
    logic              cpu_acc, rd_acc, acc, acc_we;
    logic [ADDR_W-1:0] acc_addr;
    logic [DATA_W-1:0] acc_wdata;
    owner_e            tag_in;
    logic              cpu_vld, rd_vld;
    logic [DATA_W-1:0] rdata_p;

    assign cpu_acc = cpu_req && cpu_gnt;
    assign rd_acc  = rd_req && rd_gnt;
    assign acc     = cpu_acc || rd_acc;

    // ---- Owner FSM: state register ----
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ---- Owner FSM: next state ----
    // A lock is released on the owner's final (lock=0) access or as soon as
    // the owner stops requesting.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (cpu_acc && cpu_lock) begin
                    state_nxt = ST_OWN_CPU;
                end else if (rd_acc && rd_lock) begin
                    state_nxt = ST_OWN_RD;
                end
            end
            ST_OWN_CPU: begin
                if (!cpu_req || (cpu_acc && !cpu_lock)) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_OWN_RD: begin
                if (!rd_req || (rd_acc && !rd_lock)) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // ---- Owner FSM: grant outputs ----
    // Grants are purely a function of requests, reset and FSM state; in
    // round-robin mode a tie goes to whoever was not granted last.
    always_comb begin
        cpu_gnt = 1'b0;
        rd_gnt  = 1'b0;
        if (!reset) begin
            case (state)
                ST_IDLE: begin
                    if (cpu_req && rd_req) begin
                        if (ARB_MODE == 0 || last_gnt == OWN_RD) begin
                            cpu_gnt = 1'b1;
                        end else begin
                            rd_gnt = 1'b1;
                        end
                    end else begin
                        cpu_gnt = cpu_req;
                        rd_gnt  = rd_req;
                    end
                end
                ST_OWN_CPU: cpu_gnt = cpu_req;
                ST_OWN_RD:  rd_gnt  = rd_req;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_gnt <= OWN_RD;
        end else if (cpu_acc) begin
            last_gnt <= OWN_CPU;
        end else if (rd_acc) begin
            last_gnt <= OWN_RD;
        end
    end

    // Fields of whichever access was accepted this cycle.
    always_comb begin
        acc_we    = rd_we;
        acc_addr  = rd_addr;
        acc_wdata = rd_wdata;
        tag_in    = OWN_NONE;
        if (cpu_acc) begin
            acc_we    = cpu_we;
            acc_addr  = cpu_addr;
            acc_wdata = cpu_wdata;
        end
        if (acc && !acc_we) begin
            tag_in = cpu_acc ? OWN_CPU : OWN_RD;
        end
    end

    // ---- Stage p1: RAM port registers (accept cycle + 1) ----
    always_ff @(posedge clk) begin
        if (reset) begin
            ram_ena  <= 1'b0;
            ram_wea  <= 1'b0;
            ram_addr <= '0;
            ram_din  <= '0;
        end else begin
            ram_ena <= acc;
            ram_wea <= acc && acc_we;
            if (acc) begin
                ram_addr <= acc_addr;
                ram_din  <= acc_wdata;
            end
        end
    end

    ram_rd_tag_pipe #(
        .RD_LAT (RD_LAT)
    ) u_tag_pipe (
        .clk     (clk),
        .reset   (reset),
        .tag_in  (tag_in),
        .cpu_vld (cpu_vld),
        .rd_vld  (rd_vld)
    );

    // ---- Stage p2: read response registers (accept cycle + 2 + RD_LAT) ----
    // One capture register feeds both rdata ports; only rvalid is steered.
    always_ff @(posedge clk) begin
        if (reset) begin
            cpu_rvalid <= 1'b0;
            rd_rvalid  <= 1'b0;
            rdata_p    <= '0;
        end else begin
            cpu_rvalid <= cpu_vld;
            rd_rvalid  <= rd_vld;
            if (cpu_vld || rd_vld) begin
                rdata_p <= ram_dout;
            end
        end
    end

    assign cpu_rdata = rdata_p;
    assign rd_rdata  = rdata_p;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter
// Two arbiters (fixed priority and round-robin) driven by the same requester
// stimulus, each in front of its own behavioural RAM (1-cycle douta latency).
module tb_ram_port_arbiter;

    localparam int AW = 6;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          cpu_req, cpu_we, cpu_lock;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          rd_req, rd_we, rd_lock;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_wdata;

    logic          cpu_gnt0, cpu_rvalid0, rd_gnt0, rd_rvalid0, ram_ena0, ram_wea0;
    logic [DW-1:0] cpu_rdata0, rd_rdata0, ram_din0, ram_dout0;
    logic [AW-1:0] ram_addr0;
    logic          cpu_gnt1, cpu_rvalid1, rd_gnt1, rd_rvalid1, ram_ena1, ram_wea1;
    logic [DW-1:0] cpu_rdata1, rd_rdata1, ram_din1, ram_dout1;
    logic [AW-1:0] ram_addr1;

    logic [DW-1:0] mem0 [64];
    logic [DW-1:0] mem1 [64];

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(1), .ARB_MODE(0)) u_dut0 (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_lock(cpu_lock), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_gnt(cpu_gnt0), .cpu_rvalid(cpu_rvalid0), .cpu_rdata(cpu_rdata0),
        .rd_req(rd_req), .rd_we(rd_we), .rd_lock(rd_lock), .rd_addr(rd_addr),
        .rd_wdata(rd_wdata), .rd_gnt(rd_gnt0), .rd_rvalid(rd_rvalid0), .rd_rdata(rd_rdata0),
        .ram_ena(ram_ena0), .ram_wea(ram_wea0), .ram_addr(ram_addr0), .ram_din(ram_din0),
        .ram_dout(ram_dout0)
    );

    ram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(1), .ARB_MODE(1)) u_dut1 (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_lock(cpu_lock), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_gnt(cpu_gnt1), .cpu_rvalid(cpu_rvalid1), .cpu_rdata(cpu_rdata1),
        .rd_req(rd_req), .rd_we(rd_we), .rd_lock(rd_lock), .rd_addr(rd_addr),
        .rd_wdata(rd_wdata), .rd_gnt(rd_gnt1), .rd_rvalid(rd_rvalid1), .rd_rdata(rd_rdata1),
        .ram_ena(ram_ena1), .ram_wea(ram_wea1), .ram_addr(ram_addr1), .ram_din(ram_din1),
        .ram_dout(ram_dout1)
    );

    // Single-port RAMs, douta registered one cycle after the address.
    always_ff @(posedge clk) begin
        if (ram_ena0) begin
            if (ram_wea0) mem0[ram_addr0] <= ram_din0;
            ram_dout0 <= mem0[ram_addr0];
        end
        if (ram_ena1) begin
            if (ram_wea1) mem1[ram_addr1] <= ram_din1;
            ram_dout1 <= mem1[ram_addr1];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        cpu_req = 0; cpu_we = 0; cpu_lock = 0; cpu_addr = '0; cpu_wdata = '0;
        rd_req  = 0; rd_we  = 0; rd_lock  = 0; rd_addr  = '0; rd_wdata  = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1;
        tick();
        tick();
        reset = 0;
    endtask

    // Single CPU write with the readout engine idle; granted immediately.
    task automatic cpu_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        cpu_req = 1; cpu_we = 1; cpu_lock = 0; cpu_addr = a; cpu_wdata = d;
        @(negedge clk);
        check("wr_gnt", cpu_gnt0 & cpu_gnt1, 1);
        tick();
        cpu_req = 0; cpu_we = 0;
    endtask

    initial begin
        logic g_rd, g_cpu;

        // Reset state, with requests asserted during reset
        idle_inputs();
        reset = 1;
        cpu_req = 1;
        rd_req = 1;
        tick();
        tick();
        @(negedge clk);
        check("rst_gnt", {cpu_gnt0, rd_gnt0, cpu_gnt1, rd_gnt1}, 4'b0000);
        check("rst_ram", {ram_ena0, ram_wea0, ram_addr0, ram_din0}, 0);
        check("rst_rsp", {cpu_rvalid0, rd_rvalid0, cpu_rdata0, rd_rdata0}, 0);
        idle_inputs();
        reset = 0;
        tick();

        // Single CPU write 5 = BEEF
        cpu_req = 1; cpu_we = 1; cpu_addr = 5; cpu_wdata = 16'hBEEF;
        @(negedge clk);
        check("t1_gnt", {cpu_gnt0, rd_gnt0}, 2'b10);
        tick();
        idle_inputs();
        @(negedge clk);
        check("t1_ram", {ram_ena0, ram_wea0, ram_addr0, ram_din0}, {1'b1, 1'b1, 6'd5, 16'hBEEF});
        for (int k = 0; k < 3; k++) begin
            tick();
            @(negedge clk);
            check("t1_norv", {cpu_rvalid0, rd_rvalid0}, 2'b00);
        end
        check("t1_idle", ram_ena0, 0);

        cpu_write(1, 16'h1111);
        cpu_write(2, 16'h2222);

        // Readout read of 5, latency 3
        rd_req = 1; rd_we = 0; rd_addr = 5;
        @(negedge clk);
        check("t2_gnt", {cpu_gnt0, rd_gnt0}, 2'b01);
        tick();
        idle_inputs();
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            if (k < 3) begin
                check("t2_early", rd_rvalid0, 0);
            end else begin
                check("t2_rv", {cpu_rvalid0, rd_rvalid0}, 2'b01);
                check("t2_data", rd_rdata0, 16'hBEEF);
            end
            tick();
        end
        @(negedge clk);
        check("t2_pulse", rd_rvalid0, 0);

        // Ties: fixed priority (dut0) and round-robin (dut1)
        do_reset();
        cpu_req = 1; cpu_we = 0; cpu_addr = 1;
        rd_req  = 1; rd_we  = 0; rd_addr  = 2;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            if (i < 4) begin
                check("t3_fix", {cpu_gnt0, rd_gnt0}, 2'b10);
                check("t4_rr", {cpu_gnt1, rd_gnt1}, (i % 2 == 0) ? 2'b10 : 2'b01);
            end
            if (i >= 3) begin
                check("t3_rv", {cpu_rvalid0, rd_rvalid0, cpu_rdata0}, {2'b10, 16'h1111});
                check("t4_rv", {cpu_rvalid1, rd_rvalid1}, ((i - 3) % 2 == 0) ? 2'b10 : 2'b01);
                check("t4_data", cpu_rdata1, ((i - 3) % 2 == 0) ? 16'h1111 : 16'h2222);
                check("t4_dsame", rd_rdata1, ((i - 3) % 2 == 0) ? 16'h1111 : 16'h2222);
            end
            tick();
            if (i == 3) idle_inputs();
        end

        // Lock on round-robin arbiter: preload 0..7, last grant ends on CPU
        do_reset();
        for (int a = 0; a < 8; a++) begin
            cpu_write(AW'(a), 16'hA000 + 16'(a));
        end
        cpu_req = 1; cpu_we = 1; cpu_lock = 0; cpu_addr = 9; cpu_wdata = 16'hCAFE;
        rd_req  = 1; rd_we  = 0; rd_lock  = 1; rd_addr  = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (c < 9) begin
                check("t5_cgnt", cpu_gnt1, (c == 8) ? 1 : 0);
                check("t5_rgnt", rd_gnt1, (c < 8) ? 1 : 0);
            end
            if (c >= 3) begin
                check("t5_rv", rd_rvalid1, (c <= 10) ? 1 : 0);
                if (c <= 10) check("t5_data", rd_rdata1, 16'hA000 + 16'(c - 3));
            end
            check("t5_crv", cpu_rvalid1, 0);
            g_rd = rd_gnt1;
            g_cpu = cpu_gnt1;
            tick();
            if (g_cpu) cpu_req = 0;
            if (g_rd) begin
                if (rd_addr == 7) begin
                    rd_req = 0;
                end else begin
                    rd_addr = rd_addr + 1;
                    rd_lock = (rd_addr != 7);
                end
            end
        end
        idle_inputs();
        tick();

        // Reset one cycle after a read is granted (dut1 still holds A007)
        cpu_req = 1; cpu_we = 0; cpu_addr = 3;
        @(negedge clk);
        check("t6_gnt", cpu_gnt1, 1);
        tick();
        cpu_req = 0;
        reset = 1;
        tick();
        cpu_req = 1; cpu_addr = 12;
        @(negedge clk);
        check("t6_rgnt", {cpu_gnt0, rd_gnt0, cpu_gnt1, rd_gnt1}, 4'b0000);
        check("t6_ram", {ram_ena1, ram_wea1, ram_addr1, ram_din1}, 0);
        check("t6_rsp", {cpu_rvalid1, rd_rvalid1, cpu_rdata1, rd_rdata1}, 0);
        tick();
        reset = 0;
        cpu_req = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("t6_norv", {cpu_rvalid0, rd_rvalid0, cpu_rvalid1, rd_rvalid1}, 4'b0000);
            tick();
        end
        cpu_req = 1; cpu_we = 0; cpu_addr = 9;
        @(negedge clk);
        check("t6_fgnt", cpu_gnt1, 1);
        tick();
        idle_inputs();
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            if (k < 3) begin
                check("t6_early", cpu_rvalid1, 0);
            end else begin
                check("t6_frv", {cpu_rvalid1, rd_rvalid1}, 2'b10);
                check("t6_fdata", cpu_rdata1, 16'hCAFE);
                check("t6_fdata0", {cpu_rvalid0, cpu_rdata0}, {1'b1, 16'hCAFE});
            end
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/ram_port_arbiter.md
# ram_port_arbiter

Shares the single-port 64x16 output RAM between the CPU (writes results, reads back operands) and the RAM-readout/UART engine (sequential reads for transmission). It replaces the ad hoc OR/mux of enable and address lines with a registered request/grant arbiter. It also tags every read so that the RAM output word is returned only to the requester that issued it. It sits directly in front of the RAM instance in top_level; both requesters connect only to this block.

## Interface
Parameters:
- ADDR_W, 6, RAM address width
- DATA_W, 16, RAM data width
- RD_LAT, 1, RAM douta latency in cycles after address is presented (1..3)
- ARB_MODE, 0, 0 = fixed priority (CPU wins), 1 = round-robin

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- cpu_req  in  1  CPU access request, held until granted
- cpu_we  in  1  1 = write, 0 = read
- cpu_lock  in  1  keep ownership after this access
- cpu_addr  in  ADDR_W  access address
- cpu_wdata  in  DATA_W  write data
- cpu_gnt  out  1  request accepted this cycle (combinational)
- cpu_rvalid  out  1  cpu_rdata valid, one-cycle pulse
- cpu_rdata  out  DATA_W  read data
- rd_req, rd_we, rd_lock, rd_addr, rd_wdata, rd_gnt, rd_rvalid, rd_rdata: same set for the readout engine
- ram_ena  out  1  RAM enable, registered
- ram_wea  out  1  RAM write enable, registered
- ram_addr  out  ADDR_W  registered
- ram_din  out  DATA_W  registered
- ram_dout  in  DATA_W  RAM douta

## Operation
- At most one access per cycle. An access is accepted when x_req && x_gnt.
- Owner FSM states:
  - IDLE: no lock.
  - OWN_CPU: CPU holds the lock.
  - OWN_RD: readout holds the lock.
- IDLE behaviour:
  - Single request: that requester is granted.
  - Both requesting, ARB_MODE=0: CPU is granted.
  - Both requesting, ARB_MODE=1: the requester not granted last is granted.
  - last_gnt pointer resets to readout, so the CPU wins the first tie.
- Lock:
  - An accepted access with x_lock=1 moves the FSM to OWN_x.
  - In OWN_x, only x can be granted. The other requester stalls with gnt=0.
  - OWN_x returns to IDLE in the cycle x is granted with lock=0, or the first cycle x_req=0.
  - The release cycle grants x's final access normally.
- The accepted request is registered onto ram_ena/ram_wea/ram_addr/ram_din. With no accept, ram_ena=0 and ram_wea=0, and address/data hold their last value.
- Read tagging:
  - Each accepted read pushes an owner tag into a shift pipeline RD_LAT+1 deep. Writes push "none".
  - When the tag emerges, that owner's rvalid pulses and ram_dout is captured into its rdata.
  - rdata holds between pulses. Both rdata ports carry the captured word; only the owner's rvalid pulses.
- Writes produce no response. A granted write is complete from the requester's point of view.
- Back-to-back accesses are fully pipelined (one per cycle), including read-after-write to the same address, which returns the new data.

## Timing
- Request accepted in cycle T.
- RAM pins driven in T+1.
- ram_dout valid in T+1+RD_LAT.
- x_rvalid and x_rdata presented registered in T+2+RD_LAT. With the default RD_LAT=1, read latency is 3 cycles.
- gnt depends combinationally on req, lock and FSM state. gnt must not depend on rvalid.
- Reset values: all gnt=0, all rvalid=0, rdata=0, ram_ena=0, ram_wea=0, ram_addr=0, ram_din=0. FSM=IDLE, tag pipeline cleared, last_gnt=readout.
- Reset mid-operation: in-flight reads are discarded, with no rvalid after reset deasserts. Any lock is dropped.
- Requests during reset are ignored (gnt=0).
- Requesters must hold req and fields stable until granted. The arbiter does not buffer refused requests.

## Structure
- Shared package ram_arb_pkg holds:
  - the owner enum: OWN_NONE, OWN_CPU, OWN_RD
  - FSM state encoding
  - the default ADDR_W and DATA_W
- Sub-module ram_rd_tag_pipe: parameterised RD_LAT+1-deep shift register of owner tags that emits per-owner valid strobes.
- Arbitration, FSM and the RAM output registers live in ram_port_arbiter.

## Test plan
- Reset then single CPU write: write addr 5 = 0xBEEF in cycle T.
  - ram_ena=ram_wea=1, ram_addr=5, ram_din=0xBEEF in T+1.
  - No rvalid follows.
- Read latency: readout reads addr 5 at T.
  - rd_rvalid pulses at T+3 with rd_rdata=0xBEEF.
  - cpu_rvalid stays 0.
- Tie, ARB_MODE=0: both request reads of addr 1 and 2 continuously for 4 cycles.
  - cpu_gnt every cycle, rd_gnt never.
- Tie, ARB_MODE=1: same stimulus.
  - Grants alternate CPU, RD, CPU, RD.
  - rvalids alternate with the matching addresses' data.
- Lock: readout reads addr 0..7 with rd_lock=1 (lock=0 on addr 7) while CPU requests a write.
  - CPU stalls 8 cycles, granted on the 9th.
  - Eight rd_rvalid pulses in address order.
- Reset mid-read: assert reset one cycle after a read is granted.
  - No rvalid appears.
  - All outputs at reset values.
  - A fresh CPU read after reset returns correct data at T+3.
